sq_compose: RTL and testbench
=============================

SQ_COMPOSE -- requirements
Module: sq_compose

Interface
REQ-001 NUM_SQ, 3, number of rectangles composited; index 0 has highest priority.
REQ-002 CW, 12, coordinate width for rectangle bounds.
REQ-003 i_clk  input  1  system clock, 100 MHz.
REQ-004 i_rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 i_pix_stb  input  1  pixel strobe (25 MHz enable); all pipeline advances qualified by it.
REQ-006 i_frame_stb  input  1  end-of-frame pulse from the timing generator; commits shadow bounds.
REQ-007 i_hs, i_vs  input  1 each  active-low syncs from the timing generator.
REQ-008 i_de  input  1  high in the visible 640x480 area.
REQ-009 i_x [9:0], i_y [8:0]  input  current pixel position.
REQ-010 i_x1, i_x2, i_y1, i_y2  input  NUM_SQ*CW each  packed rectangle bounds; square k occupies bits [k*CW +: CW].
REQ-011 i_rgb  input  NUM_SQ*12  packed per-square colour, {R,G,B} 4 bits each.
REQ-012 i_bg_rgb  input  12  background colour.
REQ-013 o_hs, o_vs, o_de  output  1 each  syncs and data-enable, aligned with the colour outputs.
REQ-014 o_r, o_g, o_b  output  4 each  composited pixel colour.

Function
REQ-015 Bounds and colours are held in shadow registers, loaded from the inputs on a cycle with i_frame_stb && i_pix_stb; they do not change between loads.
REQ-016 Hit rule for square k: x > x1 && x < x2 && y > y1 && y < y2, strict compares, unsigned, x/y zero-extended to CW.
REQ-017 Stage 1, on i_pix_stb: registers the NUM_SQ-bit hit vector, i_hs, i_vs, i_de, and the border flag.
REQ-018 Stage 2, on i_pix_stb: selects the colour of the lowest-index set hit bit, else i_bg_rgb; registers colour, hs, vs and de.
REQ-019 Latency is exactly 2 pixel strobes from i_x/i_y/i_hs/i_vs/i_de to the outputs; syncs and colour stay aligned.
REQ-020 When the stage-2 de is low, o_r, o_g and o_b are 0 regardless of hits or background.
REQ-021 With i_pix_stb low, every register holds its value.
REQ-022 A degenerate rectangle (x2 <= x1+1 or y2 <= y1+1) never hits.
REQ-023 i_frame_stb without i_pix_stb has no effect.
REQ-024 A shadow load in the same cycle as a stage-1 update uses the old bounds for that pixel and the new bounds from the next strobe.

Reset
REQ-025 Asserting i_rst_n low clears all registers immediately, asynchronously, including mid-line or mid-frame.
REQ-026 Reset values: o_hs=1, o_vs=1, o_de=0, o_r=o_g=o_b=0, shadow bounds and colours 0, hit vector 0.
REQ-027 Deassertion is synchronous to i_clk; the first valid output appears 2 strobes after the first strobe following release.

Configuration
REQ-028 Macro SQ_COMPOSE_BORDER_EN defined: visible pixels with x==0, x==639, y==0 or y==479 output 0xFFF (white), overriding squares and background.
REQ-029 Macro SQ_COMPOSE_BORDER_EN undefined: no border flag logic is built, and border pixels follow REQ-018.

Structure
REQ-030 Package sq_compose_pkg holds CW_DEFAULT=12, RGB_W=12, H_RES=640, V_RES=480, RGB_WHITE=12'hFFF and the per-channel slice widths.
REQ-031 Sub-module sq_hit holds one rectangle's shadow bounds and registered hit bit; it is instantiated NUM_SQ times with a generate loop.

Verification
REQ-032 Reset, then square 0 = (10,10,20,20), colour 0xF00, committed via i_frame_stb -> pixel (15,15) gives o_r=F, o_g=0, o_b=0 exactly 2 strobes later; pixel (10,15) gives the background.
REQ-033 Squares 0 and 1 overlap at (50,50), colours 0xF00 and 0x0F0 -> output is 0xF00 (priority to index 0).
REQ-034 Bounds are changed mid-frame without i_frame_stb -> output is unchanged until the next i_frame_stb && i_pix_stb, then the new bounds apply.
REQ-035 i_de=0 with i_bg_rgb=0xABC -> o_r/o_g/o_b=0; i_hs pulse delayed exactly 2 strobes on o_hs.
REQ-036 i_rst_n low for one clock mid-line -> outputs immediately o_hs=1, o_vs=1, o_de=0, colour 0; the shadowed square is no longer drawn.
REQ-037 SQ_COMPOSE_BORDER_EN defined, pixel (639,100) inside a blue square -> output 0xFFF; with the macro undefined -> output 0x00F.

Source files
------------

// File: rtl/sq_compose_pkg.sv
// rtl/sq_compose_pkg.sv - shared constants for the rectangle compositor
// Purpose: coordinate/colour widths, visible resolution and colour channel slicing.
package sq_compose_pkg;
    localparam int CW_DEFAULT = 12;
    localparam int RGB_W      = 12;
    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    // per-channel slices of a packed {R,G,B} colour
    localparam int CH_W  = 4;
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;
endpackage

// File: rtl/sq_hit.sv
// rtl/sq_hit.sv - one rectangle: shadow bounds/colour and registered hit bit
// Purpose: holds a rectangle's bounds and colour, loaded only on i_load, and
//          registers the strict-inequality hit test on each pixel strobe.
// Ports:   i_clk, i_rst_n (async active-low), i_pix_stb (advance enable),
//          i_load (shadow load), i_x1/i_x2/i_y1/i_y2/i_rgb (new bounds/colour),
//          i_px/i_py (zero-extended pixel position), o_hit (registered hit),
//          o_rgb (shadow colour).
module sq_hit
    import sq_compose_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_stb,
    input  logic             i_load,
    input  logic [CW-1:0]    i_x1,
    input  logic [CW-1:0]    i_x2,
    input  logic [CW-1:0]    i_y1,
    input  logic [CW-1:0]    i_y2,
    input  logic [RGB_W-1:0] i_rgb,
    input  logic [CW-1:0]    i_px,
    input  logic [CW-1:0]    i_py,
    output logic             o_hit,
    output logic [RGB_W-1:0] o_rgb
);
    logic [CW-1:0]    x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hit_q, hit_d;

    always_comb begin
        x1_d  = x1_q;
        x2_d  = x2_q;
        y1_d  = y1_q;
        y2_d  = y2_q;
        rgb_d = rgb_q;
        hit_d = hit_q;
        if (i_load) begin
            x1_d  = i_x1;
            x2_d  = i_x2;
            y1_d  = i_y1;
            y2_d  = i_y2;
            rgb_d = i_rgb;
        end
        // Compares use the current shadow, so a load on the same strobe
        // only affects the following pixel.
        if (i_pix_stb) begin
            hit_d = (i_px > x1_q) && (i_px < x2_q) && (i_py > y1_q) && (i_py < y2_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x1_q  <= '0;
            x2_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            rgb_q <= '0;
            hit_q <= 1'b0;
        end else begin
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            rgb_q <= rgb_d;
            hit_q <= hit_d;
        end
    end

    assign o_hit = hit_q;
    assign o_rgb = rgb_q;
endmodule

// File: rtl/sq_compose.sv
// rtl/sq_compose.sv - two-stage priority compositor of NUM_SQ rectangles
// Purpose: stage 1 registers per-square hits and syncs, stage 2 picks the
//          lowest-index hit colour (else background) and aligns syncs.
// Ports:   i_clk, i_rst_n (async active-low), i_pix_stb, i_frame_stb,
//          i_hs/i_vs (active-low), i_de, i_x/i_y, packed i_x1/i_x2/i_y1/i_y2,
//          packed i_rgb, i_bg_rgb; outputs o_hs/o_vs/o_de and o_r/o_g/o_b.
// Option:  SQ_COMPOSE_BORDER_EN draws a white one-pixel frame border.
module sq_compose
    import sq_compose_pkg::*;
#(
    parameter int NUM_SQ = 3,
    parameter int CW     = CW_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_pix_stb,
    input  logic                    i_frame_stb,
    input  logic                    i_hs,
    input  logic                    i_vs,
    input  logic                    i_de,
    input  logic [9:0]              i_x,
    input  logic [8:0]              i_y,
    input  logic [NUM_SQ*CW-1:0]    i_x1,
    input  logic [NUM_SQ*CW-1:0]    i_x2,
    input  logic [NUM_SQ*CW-1:0]    i_y1,
    input  logic [NUM_SQ*CW-1:0]    i_y2,
    input  logic [NUM_SQ*RGB_W-1:0] i_rgb,
    input  logic [RGB_W-1:0]        i_bg_rgb,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_de,
    output logic [CH_W-1:0]         o_r,
    output logic [CH_W-1:0]         o_g,
    output logic [CH_W-1:0]         o_b
);
    logic                    load;
    logic [CW-1:0]           px, py;
    logic [NUM_SQ-1:0]       hit_vec;
    logic [NUM_SQ*RGB_W-1:0] sq_rgb;
    logic [RGB_W-1:0]        sel_rgb;

    logic hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    logic hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic [RGB_W-1:0] rgb2_q, rgb2_d;

    assign load = i_frame_stb & i_pix_stb;
    assign px   = {{(CW-10){1'b0}}, i_x};
    assign py   = {{(CW-9){1'b0}}, i_y};

    for (genvar g = 0; g < NUM_SQ; g++) begin : g_sq
        sq_hit #(.CW(CW)) u_hit (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_pix_stb (i_pix_stb),
            .i_load    (load),
            .i_x1      (i_x1[g*CW +: CW]),
            .i_x2      (i_x2[g*CW +: CW]),
            .i_y1      (i_y1[g*CW +: CW]),
            .i_y2      (i_y2[g*CW +: CW]),
            .i_rgb     (i_rgb[g*RGB_W +: RGB_W]),
            .i_px      (px),
            .i_py      (py),
            .o_hit     (hit_vec[g]),
            .o_rgb     (sq_rgb[g*RGB_W +: RGB_W])
        );
    end

`ifdef SQ_COMPOSE_BORDER_EN
    logic brd1_q, brd1_d;

    always_comb begin
        brd1_d = brd1_q;
        if (i_pix_stb) begin
            brd1_d = i_de && (i_x == 10'd0 || i_x == 10'(H_RES - 1) ||
                              i_y == 9'd0  || i_y == 9'(V_RES - 1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) brd1_q <= 1'b0;
        else          brd1_q <= brd1_d;
    end
`endif

    // Priority select: scanning from the highest index down lets index 0 win.
    always_comb begin
        sel_rgb = i_bg_rgb;
        for (int k = NUM_SQ - 1; k >= 0; k--) begin
            if (hit_vec[k]) sel_rgb = sq_rgb[k*RGB_W +: RGB_W];
        end
`ifdef SQ_COMPOSE_BORDER_EN
        if (brd1_q) sel_rgb = RGB_WHITE;
`endif
        // Blanked pixels are black; stage-2 de comes from de1_q on the same strobe.
        if (!de1_q) sel_rgb = '0;
    end

    always_comb begin
        hs1_d  = hs1_q;
        vs1_d  = vs1_q;
        de1_d  = de1_q;
        hs2_d  = hs2_q;
        vs2_d  = vs2_q;
        de2_d  = de2_q;
        rgb2_d = rgb2_q;
        if (i_pix_stb) begin
            hs1_d  = i_hs;
            vs1_d  = i_vs;
            de1_d  = i_de;
            hs2_d  = hs1_q;
            vs2_d  = vs1_q;
            de2_d  = de1_q;
            rgb2_d = sel_rgb;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            de1_q  <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            de2_q  <= 1'b0;
            rgb2_q <= '0;
        end else begin
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            de1_q  <= de1_d;
            hs2_q  <= hs2_d;
            vs2_q  <= vs2_d;
            de2_q  <= de2_d;
            rgb2_q <= rgb2_d;
        end
    end

    assign o_hs = hs2_q;
    assign o_vs = vs2_q;
    assign o_de = de2_q;
    assign o_r  = rgb2_q[R_LSB +: CH_W];
    assign o_g  = rgb2_q[G_LSB +: CH_W];
    assign o_b  = rgb2_q[B_LSB +: CH_W];
endmodule

// File: tb/tb_sq_compose.sv
// tb/tb_sq_compose.sv - self-checking bench for sq_compose
module tb_sq_compose;
    localparam int N  = 3;
    localparam int CW = 12;
`ifdef SQ_COMPOSE_BORDER_EN
    localparam bit BRD = 1'b1;
`else
    localparam bit BRD = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, pix_stb = 1'b0, frame_stb = 1'b0;
    logic hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic [N*CW-1:0] x1_b = '0, x2_b = '0, y1_b = '0, y2_b = '0;
    logic [N*12-1:0] rgb_b = '0;
    logic [11:0] bg = '0;
    logic o_hs, o_vs, o_de;
    logic [3:0] o_r, o_g, o_b;

    always #5 clk = ~clk;

    sq_compose #(.NUM_SQ(N), .CW(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_frame_stb(frame_stb),
        .i_hs(hs), .i_vs(vs), .i_de(de), .i_x(x), .i_y(y),
        .i_x1(x1_b), .i_x2(x2_b), .i_y1(y1_b), .i_y2(y2_b),
        .i_rgb(rgb_b), .i_bg_rgb(bg),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    int n_cmp = 0, n_bad = 0;
    // values on the bound pins, and the model's committed (shadow) copy
    int cx1[N], cx2[N], cy1[N], cy2[N], crgb[N];
    int sx1[N], sx2[N], sy1[N], sy2[N], srgb[N];
    // model of a pixel half-way through (hit index, flags) and of the output
    int p_idx, p_de, p_hs, p_vs, p_brd;
    int e_hs, e_vs, e_de, e_rgb;

    typedef struct {
        int vx;
        int vy;
        int vde;
        int exp_rgb;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dut_out();
        return int'({o_hs, o_vs, o_de, o_r, o_g, o_b});
    endfunction

    function automatic int dut_rgb();
        return int'({o_r, o_g, o_b});
    endfunction

    function automatic int exp_out();
        return (e_hs << 14) | (e_vs << 13) | (e_de << 12) | e_rgb;
    endfunction

    function automatic int first_hit(input int px, input int py);
        for (int k = 0; k < N; k++)
            if (px > sx1[k] && px < sx2[k] && py > sy1[k] && py < sy2[k]) return k;
        return -1;
    endfunction

    task automatic set_sq(input int k, input int ax1, input int ay1, input int ax2,
                          input int ay2, input int c);
        cx1[k] = ax1; cy1[k] = ay1; cx2[k] = ax2; cy2[k] = ay2; crgb[k] = c;
        x1_b[k*CW +: CW] = CW'(ax1);
        x2_b[k*CW +: CW] = CW'(ax2);
        y1_b[k*CW +: CW] = CW'(ay1);
        y2_b[k*CW +: CW] = CW'(ay2);
        rgb_b[k*12 +: 12] = 12'(c);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            sx1[k] = 0; sx2[k] = 0; sy1[k] = 0; sy2[k] = 0; srgb[k] = 0;
        end
        p_idx = -1; p_de = 0; p_hs = 1; p_vs = 1; p_brd = 0;
        e_hs = 1; e_vs = 1; e_de = 0; e_rgb = 0;
    endtask

    // One pixel strobe (one clock of pix_stb in four), model step, output check.
    task automatic strobe(input int px, input int py, input int h, input int v,
                          input int d, input int f, input string nm);
        @(negedge clk);
        x = 10'(px); y = 9'(py); hs = h[0]; vs = v[0]; de = d[0];
        pix_stb = 1'b1; frame_stb = f[0];
        e_hs = p_hs; e_vs = p_vs; e_de = p_de;
        if (p_de == 0)      e_rgb = 0;
        else if (p_brd != 0) e_rgb = 'hFFF;
        else if (p_idx >= 0) e_rgb = srgb[p_idx];
        else                 e_rgb = int'(bg);
        p_idx = first_hit(px, py);
        p_hs = h; p_vs = v; p_de = d;
        p_brd = (BRD && d != 0 && (px == 0 || px == 639 || py == 0 || py == 479)) ? 1 : 0;
        if (f != 0) begin
            for (int k = 0; k < N; k++) begin
                sx1[k] = cx1[k]; sx2[k] = cx2[k]; sy1[k] = cy1[k]; sy2[k] = cy2[k];
                srgb[k] = crgb[k];
            end
        end
        @(negedge clk);
        pix_stb = 1'b0; frame_stb = 1'b0;
        check(nm, dut_out(), exp_out());
        repeat (2) @(negedge clk);
        check({nm, "_hold"}, dut_out(), exp_out());
    endtask

    initial begin
        for (int k = 0; k < N; k++) set_sq(k, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_out", dut_out(), 'h6000);
        rst_n = 1'b1;

        // first strobe after release, then square config from the table
        strobe(0, 0, 1, 1, 0, 0, "post_rst");
        set_sq(0, 10, 10, 20, 20, 'hF00);
        set_sq(1, 40, 40, 60, 60, 'h0F0);
        set_sq(2, 45, 45, 70, 70, 'h00F);
        bg = 12'h123;
        strobe(0, 0, 1, 1, 0, 1, "load0");

        tbl[0]  = '{15, 15, 1, 'hF00};
        tbl[1]  = '{10, 15, 1, 'h123};
        tbl[2]  = '{20, 15, 1, 'h123};
        tbl[3]  = '{11, 11, 1, 'hF00};
        tbl[4]  = '{19, 19, 1, 'hF00};
        tbl[5]  = '{50, 50, 1, 'h0F0};
        tbl[6]  = '{65, 65, 1, 'h00F};
        tbl[7]  = '{15, 15, 0, 'h000};
        tbl[8]  = '{300, 200, 1, 'h123};
        tbl[9]  = '{0, 100, 1, BRD ? 'hFFF : 'h123};
        tbl[10] = '{639, 479, 1, BRD ? 'hFFF : 'h123};
        for (int i = 0; i < 11; i++) begin
            strobe(tbl[i].vx, tbl[i].vy, 1, 1, tbl[i].vde, 0, "tbl_a");
            strobe(tbl[i].vx, tbl[i].vy, 1, 1, tbl[i].vde, 0, "tbl_b");
            check($sformatf("tbl%0d", i), dut_rgb(), tbl[i].exp_rgb);
        end

        // bounds change without a commit, stray frame pulse, then commit
        set_sq(0, 100, 100, 120, 120, 'hF00);
        strobe(15, 15, 1, 1, 1, 0, "nocommit_a");
        strobe(15, 15, 1, 1, 1, 0, "nocommit_b");
        check("nocommit", dut_rgb(), 'hF00);
        @(negedge clk); frame_stb = 1'b1;
        @(negedge clk); frame_stb = 1'b0;
        strobe(15, 15, 1, 1, 1, 0, "stray_a");
        strobe(15, 15, 1, 1, 1, 0, "stray_b");
        check("stray_frame", dut_rgb(), 'hF00);
        strobe(15, 15, 1, 1, 1, 1, "commit");
        strobe(15, 15, 1, 1, 1, 0, "commit_b");
        check("commit_old", dut_rgb(), 'hF00);
        strobe(15, 15, 1, 1, 1, 0, "commit_c");
        check("commit_new", dut_rgb(), 'h123);
        strobe(110, 110, 1, 1, 1, 0, "new_a");
        strobe(110, 110, 1, 1, 1, 0, "new_b");
        check("new_bounds", dut_rgb(), 'hF00);

        // overlapping squares 0 and 1
        set_sq(0, 45, 45, 55, 55, 'hF00);
        strobe(0, 0, 1, 1, 0, 1, "ovl_load");
        strobe(50, 50, 1, 1, 1, 0, "ovl_a");
        strobe(50, 50, 1, 1, 1, 0, "ovl_b");
        check("priority", dut_rgb(), 'hF00);

        // blanking and sync delay
        bg = 12'hABC;
        strobe(300, 300, 1, 1, 0, 0, "blank_a");
        strobe(300, 300, 1, 1, 0, 0, "blank_b");
        check("blank_rgb", dut_rgb(), 0);
        strobe(5, 5, 0, 1, 0, 0, "hs_a");
        check("hs_d1", int'(o_hs), 1);
        strobe(6, 5, 1, 1, 0, 0, "hs_b");
        check("hs_d2", int'(o_hs), 0);
        strobe(7, 5, 1, 1, 0, 0, "hs_c");
        check("hs_d3", int'(o_hs), 1);

        // border pixel inside a blue square
        set_sq(0, 0, 0, 0, 0, 'hF00);
        set_sq(1, 30, 30, 31, 40, 'h0F0);
        set_sq(2, 600, 50, 700, 200, 'h00F);
        strobe(0, 0, 1, 1, 0, 1, "blue_load");
        strobe(639, 100, 1, 1, 1, 0, "blue_a");
        strobe(639, 100, 1, 1, 1, 0, "blue_b");
        check("border_blue", dut_rgb(), BRD ? 'hFFF : 'h00F);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int rx, ry, a, b;
            if ($urandom_range(0, 15) == 0) begin
                for (int k = 0; k < N; k++) begin
                    a = int'($urandom_range(0, 120));
                    b = int'($urandom_range(0, 120));
                    set_sq(k, a, b, a + int'($urandom_range(0, 40)),
                           b + int'($urandom_range(0, 40)), int'($urandom_range(0, 4095)));
                end
            end
            if ($urandom_range(0, 9) == 0) bg = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk); frame_stb = 1'b1;
                @(negedge clk); frame_stb = 1'b0;
            end
            a = int'($urandom_range(0, 9));
            rx = (a == 0) ? 639 : (a == 1) ? 0 : int'($urandom_range(0, 170));
            a = int'($urandom_range(0, 9));
            ry = (a == 0) ? 479 : (a == 1) ? 0 : int'($urandom_range(0, 170));
            strobe(rx, ry, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) != 0) ? 1 : 0,
                   ($urandom_range(0, 7) == 0) ? 1 : 0, "rand");
        end

        // mid-line asynchronous reset drops a committed square
        set_sq(0, 10, 10, 20, 20, 'hF00);
        bg = 12'h123;
        strobe(0, 0, 1, 1, 0, 1, "rst_load");
        strobe(15, 15, 1, 1, 1, 0, "pre_rst_a");
        strobe(15, 15, 1, 1, 1, 0, "pre_rst_b");
        strobe(16, 15, 1, 1, 1, 0, "pre_rst_c");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", dut_out(), 'h6000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        strobe(15, 15, 1, 1, 1, 0, "after_rst_a");
        strobe(15, 15, 1, 1, 1, 0, "after_rst_b");
        check("shadow_cleared", dut_rgb(), 'h123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
